// File: rtl/wb_port_arbiter.sv
// Round-robin bridge from NPORTS 32-bit word requesters onto a 128-bit Wishbone classic master.
// Define WBARB_RETRY_EN to build rty_i retry handling; otherwise rty_i terminates like err_i.
module wb_port_arbiter #(
  parameter int NPORTS    = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    req_valid,
  output logic [NPORTS-1:0]    req_ready,
  input  logic [NPORTS*30-1:0] req_addr,
  input  logic [NPORTS*32-1:0] req_wdata,
  input  logic [NPORTS-1:0]    req_we,
  output logic [NPORTS-1:0]    rsp_valid,
  output logic                 rsp_err,
  output logic [31:0]          rsp_data,
  output logic [31:0]          wb_adr_o,
  output logic [127:0]         wb_dat_o,
  input  logic [127:0]         wb_dat_i,
  output logic                 wb_we_o,
  output logic [15:0]          wb_sel_o,
  output logic                 wb_stb_o,
  output logic                 wb_cyc_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i
);
  localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RETRY, RESP} state_t;
  state_t state;

  logic [NPORTS-1:0][29:0] addr_a;
  logic [NPORTS-1:0][31:0] wdata_a;
  logic [3:0][31:0]        rd_lane;
  logic [GW-1:0]           last_grant, grant, gnt_q, idx;
  logic                    found;
  logic [1:0]              lane;
  logic [7:0]              tmo_cnt;
  logic                    tmo_hit, rty_go, fail;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;
  assign rd_lane = wb_dat_i;
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

`ifdef WBARB_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] rty_cnt;
  assign rty_go = wb_rty_i && !wb_err_i && (rty_cnt != RW'(MAX_RETRY));
`else
  assign rty_go = 1'b0;
`endif

  // err beats rty beats ack; the watchdog only fires on a cycle with no termination at all
  assign fail = wb_err_i | (wb_rty_i & ~rty_go) | (~wb_rty_i & ~wb_ack_i & tmo_hit);

  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx = GW'((int'(last_grant) + k) % NPORTS);
      if (!found && req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    req_ready = '0;
    if (state == IDLE && found) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GW'(NPORTS - 1);
      gnt_q      <= '0;
      lane       <= '0;
      tmo_cnt    <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
`ifdef WBARB_RETRY_EN
      rty_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt_q    <= grant;
          lane     <= addr_a[grant][1:0];
          wb_adr_o <= {addr_a[grant][29:2], 4'h0};
          wb_sel_o <= 16'hF << {addr_a[grant][1:0], 2'b00};
          wb_dat_o <= {4{wdata_a[grant]}};
          wb_we_o  <= req_we[grant];
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          tmo_cnt  <= '0;
`ifdef WBARB_RETRY_EN
          rty_cnt  <= '0;
`endif
          state    <= BUS;
        end
        BUS: begin
          if (rty_go) begin
`ifdef WBARB_RETRY_EN
            rty_cnt <= rty_cnt + RW'(1);
`endif
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= RETRY;
          end else if (fail || wb_ack_i) begin
            wb_cyc_o         <= 1'b0;
            wb_stb_o         <= 1'b0;
            rsp_valid[gnt_q] <= 1'b1;
            rsp_err          <= fail;
            rsp_data         <= (fail || wb_we_o) ? 32'h0 : rd_lane[lane];
            state            <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
`ifdef WBARB_RETRY_EN
        RETRY: begin
          tmo_cnt  <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state    <= BUS;
        end
`endif
        RESP: begin
          rsp_valid  <= '0;
          rsp_err    <= 1'b0;
          rsp_data   <= '0;
          last_grant <= gnt_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter; reference is a per-port request table with
// arithmetic round-robin and lane math. Honors WBARB_RETRY_EN for the rty_i expectations.
module tb_wb_port_arbiter;
  localparam int NP = 2;
`ifdef WBARB_RETRY_EN
  localparam int RLIM = 3;
`else
  localparam int RLIM = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NP-1:0]   req_valid = '0;
  logic [NP-1:0]   req_ready;
  logic [NP*30-1:0] req_addr = '0;
  logic [NP*32-1:0] req_wdata = '0;
  logic [NP-1:0]   req_we = '0;
  logic [NP-1:0]   rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_data;
  logic [31:0]     wb_adr_o;
  logic [127:0]    wb_dat_o;
  logic [127:0]    wb_dat_i = '0;
  logic            wb_we_o;
  logic [15:0]     wb_sel_o;
  logic            wb_stb_o, wb_cyc_o;
  logic            wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NPORTS(NP), .MAX_RETRY(3), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  int checks = 0;
  int errors = 0;
  bit          pend    [NP];
  logic [29:0] p_addr  [NP];
  logic [31:0] p_wdata [NP];
  logic        p_we    [NP];
  int          last = NP - 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int i);
    return NP'(1) << i;
  endfunction

  function automatic logic [15:0] sel_of(input int ln);
    logic [15:0] s;
    for (int b = 0; b < 16; b++) s[b] = ((b / 4) == ln);
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      req_valid[i]          = pend[i];
      req_addr[30*i +: 30]  = p_addr[i];
      req_wdata[32*i +: 32] = p_wdata[i];
      req_we[i]             = p_we[i];
    end
  endtask

  task automatic add_req(input int p, input logic [29:0] a, input logic we, input logic [31:0] d);
    if (!pend[p]) begin
      pend[p] = 1'b1; p_addr[p] = a; p_we[p] = we; p_wdata[p] = d;
    end
    drive();
  endtask

  // One complete transaction from IDLE. term: 0 ack, 1 err, 2 silence (watchdog).
  // nrty rty_i pulses are applied first; dly idle BUS cycles precede the final termination.
  task automatic do_one(input int term, input int dly, input int nrty, input logic [127:0] line,
                        output int gout);
    int g, ln, cnt;
    bit exp_err, done;
    logic [31:0] exp_d;
    g = -1;
    for (int k = 1; k <= NP; k++)
      if (g < 0 && pend[(last + k) % NP]) g = (last + k) % NP;
    gout = g;
    if (g < 0) return;
    #1 chk("ready_grant", req_ready, oh(g));
    @(negedge clk);
    pend[g] = 1'b0;
    drive();
    ln = int'(p_addr[g][1:0]);
    chk("bus_cyc", wb_cyc_o, 1'b1);
    chk("bus_stb", wb_stb_o, 1'b1);
    chk("bus_adr", wb_adr_o, {p_addr[g][29:2], 4'h0});
    chk("bus_sel", wb_sel_o, sel_of(ln));
    chk("bus_we", wb_we_o, p_we[g]);
    chk("bus_dat", wb_dat_o, {4{p_wdata[g]}});
    chk("bus_ready0", req_ready, '0);
    wb_dat_i = line;
    exp_err = 1'b0;
    done = 1'b0;
    for (int r = 0; r < nrty && !done; r++) begin
      wb_rty_i = 1'b1;
      @(negedge clk);
      wb_rty_i = 1'b0;
      if (r < RLIM) begin
        chk("rty_gap_cyc", wb_cyc_o, 1'b0);
        chk("rty_gap_rsp", rsp_valid, '0);
        @(negedge clk);
        chk("rty_again_cyc", wb_cyc_o, 1'b1);
        chk("rty_again_adr", wb_adr_o, {p_addr[g][29:2], 4'h0});
      end else begin
        exp_err = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) begin
      if (term == 2) begin
        cnt = 1;
        while (wb_cyc_o && cnt < 400) begin
          @(negedge clk);
          if (wb_cyc_o) cnt++;
        end
        chk("timeout_cycles", cnt, 255);
        exp_err = 1'b1;
      end else begin
        repeat (dly) begin
          @(negedge clk);
          chk("hold_cyc", wb_cyc_o, 1'b1);
          chk("hold_rsp", rsp_valid, '0);
        end
        if (term == 1) wb_err_i = 1'b1; else wb_ack_i = 1'b1;
        @(negedge clk);
        wb_err_i = 1'b0;
        wb_ack_i = 1'b0;
        exp_err = (term == 1);
      end
    end
    exp_d = (exp_err || p_we[g]) ? 32'h0 : 32'(line >> (32 * ln));
    chk("rsp_valid", rsp_valid, oh(g));
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_cyc_low", wb_cyc_o, 1'b0);
    chk("rsp_stb_low", wb_stb_o, 1'b0);
    last = g;
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int gout, tr, any;
    logic [127:0] line;
    for (int i = 0; i < NP; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_we[i] = 1'b0;
    end
    drive();
    repeat (2) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_adr", wb_adr_o, '0);
    chk("rst_sel", wb_sel_o, '0);
    chk("rst_rsp", rsp_valid, '0);
    chk("rst_ready", req_ready, '0);
    rst = 1'b1;
    @(negedge clk);

    // read, lane 1
    line = {$urandom, $urandom, $urandom, $urandom};
    line[63:32] = 32'hDEADBEEF;
    add_req(0, 30'h5, 1'b0, 32'h0);
    do_one(0, 0, 0, line, gout);
    // write, lane 3
    add_req(1, 30'h3, 1'b1, 32'h12345678);
    do_one(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, gout);

    // fairness: both ports permanently requesting
    for (int i = 0; i < 4; i++) begin
      add_req(0, 30'($urandom), 1'($urandom), $urandom);
      add_req(1, 30'($urandom), 1'($urandom), $urandom);
      do_one(0, i % 2, 0, {$urandom, $urandom, $urandom, $urandom}, gout);
      chk("fair_grant", gout, i % 2);
    end

    // error, watchdog, retries (retry count must restart on each grant)
    add_req(0, 30'h42, 1'b0, 32'h0);
    do_one(1, 2, 0, {4{32'hA5A5A5A5}}, gout);
    add_req(1, 30'h77, 1'b0, 32'h0);
    do_one(2, 0, 0, {4{32'h5A5A5A5A}}, gout);
    add_req(0, 30'h9, 1'b0, 32'h0);
    do_one(0, 0, 3, {$urandom, $urandom, $urandom, $urandom}, gout);
    add_req(1, 30'hA, 1'b0, 32'h0);
    do_one(0, 1, 3, {$urandom, $urandom, $urandom, $urandom}, gout);
    add_req(0, 30'hB, 1'b1, 32'hFEEDFACE);
    do_one(0, 0, 4, {$urandom, $urandom, $urandom, $urandom}, gout);

    // reset while BUS active: port 1 wins (last was 0), then reset restores port-0 priority
    add_req(0, 30'h11, 1'b0, 32'h0);
    add_req(1, 30'h22, 1'b1, 32'hCAFEF00D);
    #1 chk("midrst_grant", req_ready, oh(1));
    @(negedge clk);
    chk("midrst_cyc_pre", wb_cyc_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("midrst_cyc", wb_cyc_o, 1'b0);
    chk("midrst_stb", wb_stb_o, 1'b0);
    @(negedge clk);
    chk("midrst_rsp", rsp_valid, '0);
    last = NP - 1;
    rst = 1'b1;
    do_one(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, gout);
    chk("postrst_first", gout, 0);
    do_one(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, gout);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      any = 0;
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 1) add_req(i, 30'($urandom), 1'($urandom), $urandom);
        if (pend[i]) any = 1;
      end
      if (any == 0) add_req(int'($urandom_range(0, NP - 1)), 30'($urandom), 1'($urandom), $urandom);
      tr = int'($urandom_range(0, 9));
      line = {$urandom, $urandom, $urandom, $urandom};
      if (tr < 6)      do_one(0, int'($urandom_range(0, 3)), 0, line, gout);
      else if (tr < 8) do_one(1, int'($urandom_range(0, 2)), 0, line, gout);
      else             do_one(0, int'($urandom_range(0, 1)), int'($urandom_range(1, 2)), line, gout);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
